// File: rtl/md_hist_decide_if.sv
// Sample-in / decision-out bus of md_hist_decide: a valid/ready stream of
// classified gradient samples in, and a held result beat out.
interface md_hist_decide_if #(
    parameter int AMP_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_bin;
    logic [AMP_W-1:0] in_amp;
    logic [3:0]       thr;
    logic             res_valid;
    logic             res_ready;
    logic [5:0]       res_mode;
    logic             res_parent_valid;
    logic [5:0]       res_parent_mode;
    logic [1:0]       res_blk_idx;

    modport master (
        output in_valid, in_bin, in_amp, thr, res_ready,
        input  in_ready, res_valid, res_mode, res_parent_valid, res_parent_mode, res_blk_idx
    );

    modport slave (
        input  in_valid, in_bin, in_amp, thr, res_ready,
        output in_ready, res_valid, res_mode, res_parent_valid, res_parent_mode, res_blk_idx
    );
endinterface

// File: rtl/md_hist_decide.sv
// Gradient-histogram mode decision: accumulates one histogram per child block and
// one per group of four children, then scans both and reports planar/DC/angular modes.
module md_hist_decide #(
    parameter int NUM_MODES = 33,
    parameter int AMP_W     = 12,
    parameter int BLK_LOG2  = 6,
    parameter int ACC_W     = AMP_W + BLK_LOG2 + 2
) (
    input  logic            clk,
    input  logic            rstn,
    md_hist_decide_if.slave bus
);
    localparam int         PROD_W   = ACC_W + 4;
    localparam logic [5:0] LAST_BIN = 6'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_SCAN,
        ST_OUT
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_child_bin  [NUM_MODES];
    logic [ACC_W-1:0]    r_parent_bin [NUM_MODES];
    logic [ACC_W-1:0]    r_child_tot;
    logic [ACC_W-1:0]    r_parent_tot;
    logic [BLK_LOG2-1:0] r_cnt;
    logic [1:0]          r_blk_idx;
    logic [5:0]          r_scan_idx;
    logic [3:0]          r_thr;
    logic [ACC_W-1:0]    r_child_max;
    logic [ACC_W-1:0]    r_parent_max;
    logic [5:0]          r_child_max_idx;
    logic [5:0]          r_parent_max_idx;

    logic                r_in_ready;
    logic                r_res_valid;
    logic [5:0]          r_res_mode;
    logic                r_res_parent_valid;
    logic [5:0]          r_res_parent_mode;
    logic [1:0]          r_res_blk_idx;

    logic                w_accept;
    logic                w_bin_ok;
    logic [ACC_W-1:0]    w_amp;
    logic                w_res_hs;
    logic                w_scan_last;
    logic [ACC_W-1:0]    w_child_cur;
    logic [ACC_W-1:0]    w_parent_cur;
    logic                w_child_take;
    logic                w_parent_take;
    logic [ACC_W-1:0]    w_child_best;
    logic [ACC_W-1:0]    w_parent_best;
    logic [5:0]          w_child_best_idx;
    logic [5:0]          w_parent_best_idx;
    logic [5:0]          w_child_mode;
    logic [5:0]          w_parent_mode;

    // best*16 < tot*thr evaluated at full width, so neither side can truncate.
    function automatic logic [5:0] decide(
        input logic [ACC_W-1:0] best,
        input logic [5:0]       best_idx,
        input logic [ACC_W-1:0] tot,
        input logic [3:0]       thr
    );
        logic [PROD_W-1:0] lhs;
        logic [PROD_W-1:0] rhs;
        lhs = {best, 4'b0000};
        rhs = PROD_W'(tot) * PROD_W'(thr);
        if (tot == '0)
            decide = 6'd1;
        else if (lhs < rhs)
            decide = 6'd0;
        else
            decide = best_idx + 6'd2;
    endfunction

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_bin_ok    = bus.in_bin < 6'(NUM_MODES);
    assign w_amp       = ACC_W'(bus.in_amp);
    assign w_res_hs    = r_res_valid && bus.res_ready;
    assign w_scan_last = (r_scan_idx == LAST_BIN);

    // Strictly-greater replacement keeps the lowest index on ties.
    assign w_child_cur       = r_child_bin[r_scan_idx];
    assign w_parent_cur      = r_parent_bin[r_scan_idx];
    assign w_child_take      = w_child_cur > r_child_max;
    assign w_parent_take     = w_parent_cur > r_parent_max;
    assign w_child_best      = w_child_take  ? w_child_cur  : r_child_max;
    assign w_parent_best     = w_parent_take ? w_parent_cur : r_parent_max;
    assign w_child_best_idx  = w_child_take  ? r_scan_idx   : r_child_max_idx;
    assign w_parent_best_idx = w_parent_take ? r_scan_idx   : r_parent_max_idx;

    assign w_child_mode  = decide(w_child_best,  w_child_best_idx,  r_child_tot,  r_thr);
    assign w_parent_mode = decide(w_parent_best, w_parent_best_idx, r_parent_tot, r_thr);

    assign bus.in_ready         = r_in_ready;
    assign bus.res_valid        = r_res_valid;
    assign bus.res_mode         = r_res_mode;
    assign bus.res_parent_valid = r_res_parent_valid;
    assign bus.res_parent_mode  = r_res_parent_mode;
    assign bus.res_blk_idx      = r_res_blk_idx;

    // NOTE: the bins are plain flops rather than a RAM because they must clear in a single cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_ACC;
            for (int k = 0; k < NUM_MODES; k++) begin
                r_child_bin[k]  <= '0;
                r_parent_bin[k] <= '0;
            end
            r_child_tot        <= '0;
            r_parent_tot       <= '0;
            r_cnt              <= '0;
            r_blk_idx          <= '0;
            r_scan_idx         <= '0;
            r_thr              <= '0;
            r_child_max        <= '0;
            r_parent_max       <= '0;
            r_child_max_idx    <= '0;
            r_parent_max_idx   <= '0;
            r_in_ready         <= 1'b1;
            r_res_valid        <= 1'b0;
            r_res_mode         <= '0;
            r_res_parent_valid <= 1'b0;
            r_res_parent_mode  <= '0;
            r_res_blk_idx      <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + BLK_LOG2'(1);
                        if (w_bin_ok) begin
                            for (int k = 0; k < NUM_MODES; k++) begin
                                if (bus.in_bin == 6'(k)) begin
                                    r_child_bin[k]  <= r_child_bin[k]  + w_amp;
                                    r_parent_bin[k] <= r_parent_bin[k] + w_amp;
                                end
                            end
                            r_child_tot  <= r_child_tot  + w_amp;
                            r_parent_tot <= r_parent_tot + w_amp;
                        end
                        if (r_cnt == '1) begin
                            r_state          <= ST_SCAN;
                            r_in_ready       <= 1'b0;
                            r_scan_idx       <= '0;
                            r_thr            <= bus.thr;
                            r_child_max      <= '0;
                            r_parent_max     <= '0;
                            r_child_max_idx  <= '0;
                            r_parent_max_idx <= '0;
                        end
                    end
                end

                ST_SCAN: begin
                    r_child_max      <= w_child_best;
                    r_parent_max     <= w_parent_best;
                    r_child_max_idx  <= w_child_best_idx;
                    r_parent_max_idx <= w_parent_best_idx;
                    r_scan_idx       <= r_scan_idx + 6'd1;
                    if (w_scan_last) begin
                        r_state            <= ST_OUT;
                        r_res_valid        <= 1'b1;
                        r_res_mode         <= w_child_mode;
                        r_res_blk_idx      <= r_blk_idx;
                        r_res_parent_valid <= (r_blk_idx == 2'd3);
                        r_res_parent_mode  <= (r_blk_idx == 2'd3) ? w_parent_mode : 6'd0;
                    end
                end

                ST_OUT: begin
                    if (w_res_hs) begin
                        for (int k = 0; k < NUM_MODES; k++) begin
                            r_child_bin[k] <= '0;
                            if (r_blk_idx == 2'd3)
                                r_parent_bin[k] <= '0;
                        end
                        r_child_tot <= '0;
                        if (r_blk_idx == 2'd3)
                            r_parent_tot <= '0;
                        r_cnt       <= '0;
                        r_blk_idx   <= r_blk_idx + 2'd1;
                        r_state     <= ST_ACC;
                        r_in_ready  <= 1'b1;
                        r_res_valid <= 1'b0;
                    end
                end

                default: r_state <= ST_ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_md_hist_decide.sv
// Self-checking bench for md_hist_decide: directed scenarios plus randomized children,
// checked against a histogram model built from the decision rules.
module tb_md_hist_decide;
    localparam int NUM_MODES = 33;
    localparam int AMP_W     = 12;
    localparam int BLK       = 64;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    md_hist_decide_if #(.AMP_W(AMP_W)) bus ();

    md_hist_decide #(
        .NUM_MODES(NUM_MODES),
        .AMP_W    (AMP_W),
        .BLK_LOG2 (6)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int last_accept_cnt = 0;

    longint m_child  [NUM_MODES];
    longint m_parent [NUM_MODES];
    longint m_child_tot;
    longint m_parent_tot;
    int     m_idx;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_mode(input longint h [NUM_MODES], input longint tot, input int thr);
        longint best = -1;
        int     bi   = 0;
        if (tot == 0) return 1;
        for (int i = 0; i < NUM_MODES; i++)
            if (h[i] > best) begin
                best = h[i];
                bi   = i;
            end
        if (best * 16 < tot * thr) return 0;
        return bi + 2;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_MODES; i++) begin
            m_child[i]  = 0;
            m_parent[i] = 0;
        end
        m_child_tot  = 0;
        m_parent_tot = 0;
        m_idx        = 0;
    endtask

    task automatic apply_reset(input string tag);
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check({tag, "_in_ready"},  32'(bus.in_ready), 1);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        check({tag, "_res_mode"},  32'(bus.res_mode), 0);
        check({tag, "_par_valid"}, 32'(bus.res_parent_valid), 0);
        check({tag, "_par_mode"},  32'(bus.res_parent_mode), 0);
        check({tag, "_blk_idx"},   32'(bus.res_blk_idx), 0);
        rstn = 1'b1;
        clear_model();
    endtask

    // Presents one sample and waits (bounded) until it is taken; starts and ends at a negedge.
    task automatic send(input int bin, input int amp);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_bin   = 6'(bin);
        bus.in_amp   = AMP_W'(amp);
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 32'(bus.in_ready), 1);
        end else begin
            last_accept_cnt = edge_cnt;
            if (bin < NUM_MODES) begin
                m_child[bin]  += amp;
                m_parent[bin] += amp;
                m_child_tot   += amp;
                m_parent_tot  += amp;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input int bin, input int amp, input int n);
        for (int i = 0; i < n; i++) send(bin, amp);
    endtask

    // Waits for the result beat, compares it with the model (and optional fixed values),
    // optionally stalls res_ready, then completes the handshake and advances the model.
    task automatic expect_result(input string tag, input int stall, input int exp_mode, input int exp_pmode);
        int guard = 0;
        int em;
        int epm;
        logic [5:0] held_mode;
        logic [1:0] held_idx;
        bus.res_ready = (stall == 0);
        while (!bus.res_valid && guard < 200) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_bin   = 6'($urandom_range(0, 40));
            bus.in_amp   = AMP_W'($urandom);
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_res_valid"}, 32'(bus.res_valid), 1);
        if (!bus.res_valid) return;
        check({tag, "_latency"}, 32'(edge_cnt - last_accept_cnt), 34);
        em  = ref_mode(m_child, m_child_tot, int'(bus.thr));
        epm = (m_idx == 3) ? ref_mode(m_parent, m_parent_tot, int'(bus.thr)) : 0;
        check({tag, "_mode"},      32'(bus.res_mode), 32'(em));
        check({tag, "_blk_idx"},   32'(bus.res_blk_idx), 32'(m_idx));
        check({tag, "_par_valid"}, 32'(bus.res_parent_valid), 32'(m_idx == 3));
        check({tag, "_par_mode"},  32'(bus.res_parent_mode), 32'(epm));
        if (exp_mode >= 0)  check({tag, "_mode_fixed"}, 32'(bus.res_mode), 32'(exp_mode));
        if (exp_pmode >= 0) check({tag, "_par_fixed"},  32'(bus.res_parent_mode), 32'(exp_pmode));
        held_mode = bus.res_mode;
        held_idx  = bus.res_blk_idx;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'(i % 2);
            bus.in_bin   = 6'($urandom_range(0, 32));
            bus.in_amp   = AMP_W'($urandom);
            @(negedge clk);
            check({tag, "_stall_valid"},    32'(bus.res_valid), 1);
            check({tag, "_stall_mode"},     32'(bus.res_mode), 32'(held_mode));
            check({tag, "_stall_idx"},      32'(bus.res_blk_idx), 32'(held_idx));
            check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check({tag, "_hs_in_ready"},  32'(bus.in_ready), 1);
        check({tag, "_hs_res_valid"}, 32'(bus.res_valid), 0);
        for (int i = 0; i < NUM_MODES; i++) m_child[i] = 0;
        m_child_tot = 0;
        if (m_idx == 3) begin
            for (int i = 0; i < NUM_MODES; i++) m_parent[i] = 0;
            m_parent_tot = 0;
        end
        m_idx = (m_idx + 1) % 4;
    endtask

    initial begin
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bin    = '0;
        bus.in_amp    = '0;
        bus.thr       = 4'd4;
        bus.res_ready = 1'b1;
        clear_model();
        @(negedge clk);
        apply_reset("rst0");

        // Single dominant bin.
        bus.thr = 4'd4;
        send_block(24, 100, BLK);
        expect_result("t1", 0, 26, -1);

        // Tie between bins 0 and 8 resolves to the lower index.
        bus.thr = 4'd0;
        send_block(0, 50, 32);
        send_block(8, 50, 32);
        expect_result("t2", 0, 2, -1);

        // Zero totals give DC, including all samples out of range.
        bus.thr = 4'd4;
        send_block(3, 0, BLK);
        expect_result("t3a", 0, 1, -1);
        send_block(40, 500, BLK);
        expect_result("t3b", 0, 1, -1);

        // Flat histogram: planar with thr=4, lowest angular bin with thr=0.
        for (int i = 0; i < BLK; i++) send(i % 32, 10);
        expect_result("t4a", 0, 0, -1);
        bus.thr = 4'd0;
        for (int i = 0; i < BLK; i++) send(i % 32, 10);
        expect_result("t4b", 0, 2, -1);

        // Four children forming one parent.
        apply_reset("rst1");
        bus.thr = 4'd4;
        for (int c = 0; c < 3; c++) begin
            send_block(10, 5, BLK);
            expect_result($sformatf("t5c%0d", c), 0, 12, -1);
        end
        send_block(20, 20, BLK);
        expect_result("t5c3", 0, 22, 22);
        send_block(17, 9, BLK);
        expect_result("t5next", 0, 19, -1);

        // Backpressure with ignored input pulses, then a mid-block reset.
        send_block(30, 11, BLK);
        expect_result("t6stall", 10, 32, -1);
        send_block(12, 3, 30);
        apply_reset("rst2");
        send_block(5, 7, BLK);
        expect_result("t6clean", 0, 7, -1);

        // Randomized children across two parents.
        for (int c = 0; c < 8; c++) begin
            int dom;
            int style;
            bus.thr = 4'($urandom_range(0, 15));
            dom     = $urandom_range(0, NUM_MODES - 1);
            style   = $urandom_range(0, 2);
            for (int i = 0; i < BLK; i++) begin
                int b;
                if (style == 0)
                    b = $urandom_range(0, 39);
                else
                    b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_MODES - 1) : dom;
                send(b, $urandom_range(0, (1 << AMP_W) - 1));
            end
            expect_result($sformatf("rnd%0d", c), $urandom_range(0, 3), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
